// File: rtl/ncl_mult_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ncl_mult_pipe : dual-rail NCL A_W x B_W multiplier, STAGES-deep pipeline   |
// | Optional: NCL_MULT_SIGNED_EN selects a two's-complement product.           |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module ncl_mult_pipe #(
  parameter int A_W    = 3,
  parameter int B_W    = 3,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [A_W-1:0]       a_r1,
  input  logic [A_W-1:0]       a_r0,
  input  logic [B_W-1:0]       b_r1,
  input  logic [B_W-1:0]       b_r0,
  output logic                 ko,
  input  logic                 ki,
  output logic [A_W+B_W-1:0]   p_r1,
  output logic [A_W+B_W-1:0]   p_r0,
  output logic                 err,
  output logic [CNT_W-1:0]     tok_cnt
);

  localparam int W    = A_W + B_W;
  localparam int LAST = STAGES - 1;

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("ncl_mult_pipe: STAGES must be at least 2");
    end
  endgenerate

  logic in_complete_w, in_null_w, in_illegal_w;

  assign in_complete_w = &{a_r1 ^ a_r0, b_r1 ^ b_r0};
  assign in_null_w     = ~|{a_r1, a_r0, b_r1, b_r0};
  assign in_illegal_w  = |{a_r1 & a_r0, b_r1 & b_r0};

  // phase bit per stage: 1 = holds DATA, 0 = holds NULL
  logic [STAGES-1:0] phase_q, phase_d;
  logic [STAGES-1:0] src_data_w, src_null_w, ack_w, cap_data_w, cap_null_w;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    src_data_w = {phase_q[STAGES-2:0], in_complete_w};
    src_null_w = {~phase_q[STAGES-2:0], in_null_w};
    ack_w      = {ki, ~phase_q[STAGES-1:1]};
    cap_data_w = ~phase_q & src_data_w & ack_w;
    cap_null_w = phase_q & src_null_w & ~ack_w;
    phase_d    = (phase_q | cap_data_w) & ~cap_null_w;
    err_d      = err_q | in_illegal_w;
    cnt_d      = cap_null_w[LAST] ? cnt_q + CNT_W'(1) : cnt_q;
  end

  logic [W-1:0]   ops_q;
  logic [W-1:0]   prod_w;
  logic [A_W-1:0] op_a_w;
  logic [B_W-1:0] op_b_w;

  assign op_a_w = ops_q[W-1:B_W];
  assign op_b_w = ops_q[B_W-1:0];

`ifdef NCL_MULT_SIGNED_EN
  logic signed [W-1:0] a_ext_w, b_ext_w;
  assign a_ext_w = {{B_W{op_a_w[A_W-1]}}, op_a_w};
  assign b_ext_w = {{A_W{op_b_w[B_W-1]}}, op_b_w};
  assign prod_w  = a_ext_w * b_ext_w;
`else
  assign prod_w  = {{B_W{1'b0}}, op_a_w} * {{A_W{1'b0}}, op_b_w};
`endif

  logic [W-1:0] prod_q [1:STAGES-1];

  // values only move on a DATA capture; a NULL stage's value is masked at the output
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      ops_q   <= '0;
      for (int k = 1; k < STAGES; k++) prod_q[k] <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      if (cap_data_w[0]) ops_q <= {a_r1, b_r1};
      if (cap_data_w[1]) prod_q[1] <= prod_w;
      for (int k = 2; k < STAGES; k++) begin
        if (cap_data_w[k]) prod_q[k] <= prod_q[k-1];
      end
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ko      = ~phase_q[0];
  assign p_r1    = phase_q[LAST] ? prod_q[LAST]  : '0;
  assign p_r0    = phase_q[LAST] ? ~prod_q[LAST] : '0;
  assign err     = err_q;
  assign tok_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ncl_mult_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ncl_mult_pipe : directed table, corner sequences and random handshake  |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_ncl_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  a_r1, a_r0, b_r1, b_r0;
  logic        ki;
  wire         ko;
  wire  [5:0]  p_r1, p_r0;
  wire         err;
  wire  [15:0] tok_cnt;

  logic [3:0]  a4_r1, a4_r0, b4_r1, b4_r0;
  logic        ki4;
  wire         ko4;
  wire  [7:0]  p4_r1, p4_r0;
  wire         err4;
  wire  [15:0] tok4;

  ncl_mult_pipe #(.A_W(3), .B_W(3), .STAGES(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .a_r1(a_r1), .a_r0(a_r0), .b_r1(b_r1), .b_r0(b_r0),
    .ko(ko), .ki(ki), .p_r1(p_r1), .p_r0(p_r0),
    .err(err), .tok_cnt(tok_cnt)
  );

  ncl_mult_pipe #(.A_W(4), .B_W(4), .STAGES(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst(rst),
    .a_r1(a4_r1), .a_r0(a4_r0), .b_r1(b4_r1), .b_r0(b4_r0),
    .ko(ko4), .ki(ki4), .p_r1(p4_r1), .p_r0(p4_r0),
    .err(err4), .tok_cnt(tok4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ab(input logic [2:0] a, input logic [2:0] b);
    a_r1 = a; a_r0 = ~a; b_r1 = b; b_r0 = ~b;
  endtask

  task automatic set_null();
    a_r1 = '0; a_r0 = '0; b_r1 = '0; b_r0 = '0;
  endtask

  // product straight from the arithmetic definition
  function automatic logic [5:0] model_mul(input int a, input int b);
    int sa, sb;
    sa = a; sb = b;
`ifdef NCL_MULT_SIGNED_EN
    if (sa >= 4) sa -= 8;
    if (sb >= 4) sb -= 8;
`endif
    return 6'((sa * sb) & 63);
  endfunction

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [5:0] p;
  } vec_t;

  vec_t       tbl [7];
  logic [5:0] e, ne;
  logic [2:0] ra, rb;
  logic [5:0] expq [$];
  int         pstate, seen, produced, model_cnt;
  localparam int NTOK = 150;

  initial begin
`ifdef NCL_MULT_SIGNED_EN
    tbl[0] = '{3'd5, 3'd7, 6'd3};
    tbl[1] = '{3'd3, 3'd6, 6'b111010};
    tbl[2] = '{3'd0, 3'd0, 6'd0};
    tbl[3] = '{3'd7, 3'd7, 6'd1};
    tbl[4] = '{3'd1, 3'd7, 6'd63};
    tbl[5] = '{3'd7, 3'd0, 6'd0};
    tbl[6] = '{3'd5, 3'd2, 6'b111010};
`else
    tbl[0] = '{3'd5, 3'd7, 6'b100011};
    tbl[1] = '{3'd3, 3'd6, 6'd18};
    tbl[2] = '{3'd0, 3'd0, 6'd0};
    tbl[3] = '{3'd7, 3'd7, 6'd49};
    tbl[4] = '{3'd1, 3'd7, 6'd7};
    tbl[5] = '{3'd7, 3'd0, 6'd0};
    tbl[6] = '{3'd5, 3'd2, 6'd10};
`endif

    rst = 1'b1; ki = 1'b1; set_null();
    a4_r1 = '0; a4_r0 = '0; b4_r1 = '0; b4_r0 = '0; ki4 = 1'b1;
    tick(2);
    rst = 1'b0;
    tick();

    chk("reset_p_r1", p_r1, 6'd0);
    chk("reset_p_r0", p_r0, 6'd0);
    chk("reset_ko", ko, 1'b1);
    chk("reset_err", err, 1'b0);
    chk("reset_tok", tok_cnt, 16'd0);

    // table: one full DATA/NULL wavefront per entry
    for (int i = 0; i < 7; i++) begin
      ki = 1'b1;
      set_ab(tbl[i].a, tbl[i].b);
      tick();
      chk("tbl_ko_after_edge1", ko, 1'b0);
      chk("tbl_out_null_edge1", p_r1 | p_r0, 6'd0);
      tick();
      ne = ~tbl[i].p;
      chk("tbl_p_r1", p_r1, tbl[i].p);
      chk("tbl_p_r0", p_r0, ne);
      set_null(); ki = 1'b0;
      tick(2);
      chk("tbl_null_out", p_r1 | p_r0, 6'd0);
      chk("tbl_tok", tok_cnt, 16'(i + 1));
      chk("tbl_ko_null", ko, 1'b1);
      ki = 1'b1;
    end

    // consumer stalls with DATA at the output while the next word waits
    set_ab(3'd5, 3'd7);
    tick(2);
    chk("bp_first", p_r1, tbl[0].p);
    set_null();
    tick();
    chk("bp_ko_null", ko, 1'b1);
    set_ab(3'd3, 3'd6);
    tick(3);
    chk("bp_held_ko", ko, 1'b1);
    chk("bp_held_out", p_r1, tbl[0].p);
    ki = 1'b0;
    tick();
    chk("bp_out_null", p_r1 | p_r0, 6'd0);
    chk("bp_tok", tok_cnt, 16'd8);
    ki = 1'b1;
    tick();
    chk("bp_ko_fill", ko, 1'b0);
    tick();
    chk("bp_second", p_r1, tbl[1].p);
    set_null(); ki = 1'b0;
    tick(2);
    chk("bp_tok2", tok_cnt, 16'd9);
    ki = 1'b1;

    // incomplete word: A valid, B rails all low
    a_r1 = 3'd5; a_r0 = 3'd2; b_r1 = '0; b_r0 = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("inc_ko", ko, 1'b1);
      chk("inc_out", p_r1 | p_r0, 6'd0);
    end
    b_r1 = 3'd7; b_r0 = 3'd0;
    tick();
    chk("inc_capture_ko", ko, 1'b0);
    tick();
    chk("inc_p", p_r1, tbl[0].p);
    set_null(); ki = 1'b0;
    tick(2);
    ki = 1'b1;

    // illegal code on A[1]
    a_r1 = 3'b011; a_r0 = 3'b110; b_r1 = 3'd2; b_r0 = 3'd5;
    tick();
    chk("ill_err", err, 1'b1);
    chk("ill_no_capture", ko, 1'b1);
    set_null();
    tick();
    set_ab(3'd3, 3'd6);
    tick(2);
    chk("ill_legal_p", p_r1, tbl[1].p);
    chk("ill_err_sticky", err, 1'b1);
    set_null(); ki = 1'b0;
    tick(2);
    ki = 1'b1;

    // reset with DATA in stage 0
    set_ab(3'd7, 3'd7);
    tick();
    chk("rst_pre_ko", ko, 1'b0);
    rst = 1'b1;
    tick();
    chk("rst_p_r1", p_r1, 6'd0);
    chk("rst_p_r0", p_r0, 6'd0);
    chk("rst_ko", ko, 1'b1);
    chk("rst_tok", tok_cnt, 16'd0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    set_null();
    tick();

    // deep 4x4 instance, 4-edge latency
    a4_r1 = 4'd15; a4_r0 = 4'd0; b4_r1 = 4'd13; b4_r0 = 4'd2; ki4 = 1'b1;
    tick(3);
    chk("w4_null_edge3", p4_r1 | p4_r0, 8'd0);
    tick();
`ifdef NCL_MULT_SIGNED_EN
    chk("w4_p_r1", p4_r1, 8'h03);
    chk("w4_p_r0", p4_r0, 8'hFC);
`else
    chk("w4_p_r1", p4_r1, 8'hC3);
    chk("w4_p_r0", p4_r0, 8'h3C);
`endif
    a4_r1 = '0; a4_r0 = '0; b4_r1 = '0; b4_r0 = '0; ki4 = 1'b0;

    // random producer/consumer handshakes against the token model
    pstate = 0; seen = 0; produced = 0; model_cnt = 0;
    ki = 1'b1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (produced == NTOK && expq.size() == 0 && pstate == 0) break;
      if ((p_r1 | p_r0) != 6'd0) begin
        if (seen == 0) begin
          seen = 1;
          if (expq.size() == 0) begin
            chk("rnd_unexpected_token", p_r1, 6'd0);
          end else begin
            e  = expq.pop_front();
            ne = ~e;
            chk("rnd_p_r1", p_r1, e);
            chk("rnd_p_r0", p_r0, ne);
          end
        end else if (ki && $urandom_range(0, 1) == 1) begin
          ki = 1'b0;
        end
      end else begin
        if (seen != 0) begin
          seen = 0;
          model_cnt++;
          chk("rnd_tok", tok_cnt, 16'(model_cnt));
        end
        if (!ki && $urandom_range(0, 1) == 1) ki = 1'b1;
      end
      case (pstate)
        0: if (ko && produced < NTOK && $urandom_range(0, 2) != 0) begin
             ra = 3'($urandom); rb = 3'($urandom);
             a_r1 = ra; a_r0 = ~ra;
             pstate = 1;
           end
        1: if ($urandom_range(0, 1) == 1) begin
             b_r1 = rb; b_r0 = ~rb;
             expq.push_back(model_mul(int'(ra), int'(rb)));
             produced++;
             pstate = 2;
           end
        2: if (!ko) begin
             a_r1 = '0; a_r0 = '0;
             pstate = 3;
           end
        default: if ($urandom_range(0, 1) == 1) begin
             b_r1 = '0; b_r0 = '0;
             pstate = 0;
           end
      endcase
      tick();
    end
    chk("rnd_all_produced", produced, NTOK);
    chk("rnd_queue_drained", expq.size(), 0);
    chk("rnd_err_clear", err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
